// File: rtl/traffic_demand_conditioner_pkg.sv
// Light-code constants shared between the demand conditioner and the traffic light controller.
package traffic_demand_conditioner_pkg;

   localparam logic [1:0] GREEN     = 2'b00;
   localparam logic [1:0] YELLOW    = 2'b01;
   localparam logic [1:0] RED       = 2'b10;
   localparam logic [1:0] REDYELLOW = 2'b11;

   function automatic logic is_green(input logic [1:0] light);
      return light == GREEN;
   endfunction

endpackage

// File: rtl/demand_channel.sv
// One detector channel: two-flop synchroniser, debounce counter and a pending-demand latch
// that is cleared when the road is served.
module demand_channel #(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sense,
   input  logic i_clear,
   output logic o_demand
);

   localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            demand_q, demand_d;
   logic            detect;

   always_comb begin
      sync1_d = i_sense;
      sync2_d = sync1_q;
      // Fires on the edge the counter reaches DEBOUNCE; saturation blocks any re-fire.
      detect  = sync2_q && (cnt_q == CntW'(DEBOUNCE - 1));

      if (!sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntW'(DEBOUNCE)) begin
         cnt_d = cnt_q + CntW'(1);
      end else begin
         cnt_d = cnt_q;
      end

      // A vehicle arriving on its own green is already served, so clear wins.
      if (i_clear) begin
         demand_d = 1'b0;
      end else if (detect) begin
         demand_d = 1'b1;
      end else begin
         demand_d = demand_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         demand_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cnt_q    <= cnt_d;
         demand_q <= demand_d;
      end
   end

   assign o_demand = demand_q;

endmodule

// File: rtl/traffic_demand_conditioner.sv
// Turns raw vehicle detectors into the controller's active-low phase-advance requests,
// gated by a minimum green dwell on the road being asked to yield.
module traffic_demand_conditioner
   import traffic_demand_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE  = 4,
   parameter int unsigned MIN_GREEN = 8
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_sense_a,
   input  logic       i_sense_b,
   input  logic [1:0] i_light_a,
   input  logic [1:0] i_light_b,
   output logic       o_test_a,
   output logic       o_test_b,
   output logic       o_demand_a,
   output logic       o_demand_b
);

   localparam int unsigned DwW = (MIN_GREEN > 0) ? $clog2(MIN_GREEN + 1) : 1;

   logic           green_a, green_b;
   logic           demand_a, demand_b;
   logic           dwell_ok_a, dwell_ok_b;
   logic [DwW-1:0] dwell_a_q, dwell_a_d;
   logic [DwW-1:0] dwell_b_q, dwell_b_d;
   logic           test_a_q, test_a_d;
   logic           test_b_q, test_b_d;
   logic           demand_a_q, demand_a_d;
   logic           demand_b_q, demand_b_d;

   assign green_a = is_green(i_light_a);
   assign green_b = is_green(i_light_b);

   demand_channel #(.DEBOUNCE(DEBOUNCE)) u_chan_a (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_sense  (i_sense_a),
      .i_clear  (green_a),
      .o_demand (demand_a)
   );

   demand_channel #(.DEBOUNCE(DEBOUNCE)) u_chan_b (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_sense  (i_sense_b),
      .i_clear  (green_b),
      .o_demand (demand_b)
   );

   always_comb begin
      dwell_ok_a = (dwell_a_q == DwW'(MIN_GREEN));
      dwell_ok_b = (dwell_b_q == DwW'(MIN_GREEN));

      if (!green_a) begin
         dwell_a_d = '0;
      end else if (!dwell_ok_a) begin
         dwell_a_d = dwell_a_q + DwW'(1);
      end else begin
         dwell_a_d = dwell_a_q;
      end

      if (!green_b) begin
         dwell_b_d = '0;
      end else if (!dwell_ok_b) begin
         dwell_b_d = dwell_b_q + DwW'(1);
      end else begin
         dwell_b_d = dwell_b_q;
      end

      // Each road yields on the other road's demand.
      test_a_d   = ~(demand_b & dwell_ok_a);
      test_b_d   = ~(demand_a & dwell_ok_b);
      demand_a_d = demand_a;
      demand_b_d = demand_b;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         dwell_a_q  <= '0;
         dwell_b_q  <= '0;
         test_a_q   <= 1'b1;
         test_b_q   <= 1'b1;
         demand_a_q <= 1'b0;
         demand_b_q <= 1'b0;
      end else begin
         dwell_a_q  <= dwell_a_d;
         dwell_b_q  <= dwell_b_d;
         test_a_q   <= test_a_d;
         test_b_q   <= test_b_d;
         demand_a_q <= demand_a_d;
         demand_b_q <= demand_b_d;
      end
   end

   assign o_test_a   = test_a_q;
   assign o_test_b   = test_b_q;
   assign o_demand_a = demand_a_q;
   assign o_demand_b = demand_b_q;

endmodule
